// File: rtl/slurm_pkg.sv
// Shared slurm-next constants: datapath widths, idle scratch register and
// architectural register indices. Also the writeback source select type.
package slurm_pkg;

  localparam int REG_BITS = 5;
  localparam int BITS     = 16;
  localparam int LD_DEPTH = 4;

  localparam logic [REG_BITS-1:0] IDLE_REG = 5'd31;

  localparam logic [REG_BITS-1:0] REG_FP  = 5'd12;
  localparam logic [REG_BITS-1:0] REG_SP  = 5'd13;
  localparam logic [REG_BITS-1:0] REG_ILR = 5'd14;
  localparam logic [REG_BITS-1:0] REG_LR  = 5'd15;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_ALU,
    WB_MEM
  } wb_src_e;

endpackage

// File: rtl/wb_pending_fifo.sv
// In-order queue of pending load destinations, with a parallel compare of
// three register indices against every live entry.
module wb_pending_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic         clk_i,
  input  logic         rst_b_i,
  input  logic         push_i,
  input  logic [W-1:0] push_reg_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o,
  input  logic [W-1:0] match_a_reg_i,
  input  logic [W-1:0] match_b_reg_i,
  input  logic [W-1:0] match_c_reg_i,
  output logic         match_a_o,
  output logic         match_b_o,
  output logic         match_c_o
);

  localparam int PTR = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [PTR:0]     cnt_q, cnt_d;
  logic [DEPTH-1:0] valid, hit_a, hit_b, hit_c;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) wr_d = wr_q + 1'b1;
    if (pop_i)  rd_d = rd_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_b_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: liveness is decided by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= push_reg_i;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    localparam logic [PTR-1:0] IDX = PTR'(i);
    logic [PTR-1:0] off;
    assign off      = IDX - rd_q;
    assign valid[i] = {1'b0, off} < cnt_q;
    assign hit_a[i] = valid[i] && (mem_q[i] == match_a_reg_i);
    assign hit_b[i] = valid[i] && (mem_q[i] == match_b_reg_i);
    assign hit_c[i] = valid[i] && (mem_q[i] == match_c_reg_i);
  end

  assign head_o    = mem_q[rd_q];
  assign full_o    = (cnt_q == (PTR+1)'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign match_a_o = |hit_a;
  assign match_b_o = |hit_b;
  assign match_c_o = |hit_c;

endmodule

// File: rtl/writeback_stage.sv
// Writeback arbiter in front of the register-file write port: memory > ALU > idle.
// Optional WB_SCOREBOARD_EN enables load-use stall and WAW blocking of ALU writes.
module writeback_stage #(
  parameter int                  REG_BITS = slurm_pkg::REG_BITS,
  parameter int                  BITS     = slurm_pkg::BITS,
  parameter int                  LD_DEPTH = slurm_pkg::LD_DEPTH,
  parameter logic [REG_BITS-1:0] IDLE_REG = slurm_pkg::IDLE_REG
) (
  input  logic                CLK,
  input  logic                RSTb,
  input  logic                alu_valid,
  input  logic [REG_BITS-1:0] alu_reg,
  input  logic [BITS-1:0]     alu_data,
  output logic                alu_ready,
  input  logic                ld_issue,
  input  logic [REG_BITS-1:0] ld_reg,
  output logic                ld_ready,
  input  logic                mem_valid,
  input  logic [BITS-1:0]     mem_data,
  input  logic [REG_BITS-1:0] hazA_reg,
  input  logic [REG_BITS-1:0] hazB_reg,
  output logic                haz_stall,
  output logic                mem_err,
  output logic [REG_BITS-1:0] regIn,
  output logic [BITS-1:0]     regIn_data
);

  import slurm_pkg::*;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [REG_BITS-1:0] fifo_head;
  logic                match_a, match_b, match_alu;
  logic                waw;
  wb_src_e             src;
  logic [REG_BITS-1:0] reg_d, reg_q;
  logic [BITS-1:0]     data_d, data_q;
  logic                mem_err_d, mem_err_q;

  wb_pending_fifo #(
    .DEPTH (LD_DEPTH),
    .W     (REG_BITS)
  ) u_pending (
    .clk_i         (CLK),
    .rst_b_i       (RSTb),
    .push_i        (fifo_push),
    .push_reg_i    (ld_reg),
    .pop_i         (fifo_pop),
    .head_o        (fifo_head),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .match_a_reg_i (hazA_reg),
    .match_b_reg_i (hazB_reg),
    .match_c_reg_i (alu_reg),
    .match_a_o     (match_a),
    .match_b_o     (match_b),
    .match_c_o     (match_alu)
  );

  // A pop frees a slot in the same cycle, so a full queue can still take a push.
  assign fifo_pop  = mem_valid & ~fifo_empty;
  assign ld_ready  = ~fifo_full | fifo_pop;
  assign fifo_push = ld_issue & ld_ready;

`ifdef WB_SCOREBOARD_EN
  assign waw       = match_alu;
  assign haz_stall = match_a | match_b;
`else
  logic unused_match;
  assign unused_match = match_a ^ match_b ^ match_alu;
  assign waw          = 1'b0;
  assign haz_stall    = 1'b0;
`endif

  assign alu_ready = alu_valid & ~fifo_pop & ~waw;

  always_comb begin
    src       = WB_IDLE;
    reg_d     = IDLE_REG;
    data_d    = '0;
    mem_err_d = mem_err_q | (mem_valid & fifo_empty);
    if (fifo_pop)       src = WB_MEM;
    else if (alu_ready) src = WB_ALU;
    case (src)
      WB_MEM: begin
        reg_d  = fifo_head;
        data_d = mem_data;
      end
      WB_ALU: begin
        reg_d  = alu_reg;
        data_d = alu_data;
      end
      default: begin
        reg_d  = IDLE_REG;
        data_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      reg_q     <= IDLE_REG;
      data_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      reg_q     <= reg_d;
      data_q    <= data_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign regIn      = reg_q;
  assign regIn_data = data_q;
  assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: stimulus queues expected writes tagged
// with the edge that produces them; a negedge monitor pops and compares.
module tb_writeback_stage;

`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RSTb;
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [15:0] alu_data;
  logic        alu_ready;
  logic        ld_issue;
  logic [4:0]  ld_reg;
  logic        ld_ready;
  logic        mem_valid;
  logic [15:0] mem_data;
  logic [4:0]  hazA_reg, hazB_reg;
  logic        haz_stall;
  logic        mem_err;
  logic [4:0]  regIn;
  logic [15:0] regIn_data;

  writeback_stage dut (
    .CLK        (CLK),
    .RSTb       (RSTb),
    .alu_valid  (alu_valid),
    .alu_reg    (alu_reg),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .ld_issue   (ld_issue),
    .ld_reg     (ld_reg),
    .ld_ready   (ld_ready),
    .mem_valid  (mem_valid),
    .mem_data   (mem_data),
    .hazA_reg   (hazA_reg),
    .hazB_reg   (hazB_reg),
    .haz_stall  (haz_stall),
    .mem_err    (mem_err),
    .regIn      (regIn),
    .regIn_data (regIn_data)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    logic [4:0]  r;
    logic [15:0] d;
  } exp_t;

  exp_t sb_q[$];
  int   cyc_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;

  always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

  always @(negedge CLK) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_cnt) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      if (e.cyc != cyc_cnt || regIn !== e.r || regIn_data !== e.d) begin
        errors++;
        $display("FAIL wb_write edge=%0d: got reg=%0d data=%h, expected reg=%0d data=%h (edge %0d)",
                 cyc_cnt, regIn, regIn_data, e.r, e.d, e.cyc);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Queue the write expected from the next edge, then advance past it.
  task automatic step(input logic [4:0] r, input logic [15:0] d);
    sb_q.push_back('{cyc_cnt + 1, r, d});
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    RSTb = 1'b0; alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
    ld_issue = 1'b0; ld_reg = '0; mem_valid = 1'b0; mem_data = '0;
    hazA_reg = '0; hazB_reg = '0;
    @(posedge CLK);
    #1;
    step(5'd31, 16'h0000);
    RSTb = 1'b1;
    #1;
    chk("reset_ld_ready", ld_ready, 1);
    chk("reset_haz_stall", haz_stall, 0);
    chk("reset_mem_err", mem_err, 0);
    for (int i = 0; i < 5; i++) begin
      chk("idle_ld_ready", ld_ready, 1);
      step(5'd31, 16'h0000);
    end

    // ALU write
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 16'h1234;
    #1 chk("alu_ready_basic", alu_ready, 1);
    step(5'd3, 16'h1234);
    alu_valid = 1'b0;

    // Memory response beats ALU
    ld_issue = 1'b1; ld_reg = 5'd5;
    #1 chk("ld_ready_r5", ld_ready, 1);
    step(5'd31, 16'h0000);
    ld_issue = 1'b0;
    mem_valid = 1'b1; mem_data = 16'hBEEF;
    alu_valid = 1'b1; alu_reg = 5'd2; alu_data = 16'h0222;
    #1 chk("alu_ready_blocked_by_mem", alu_ready, 0);
    step(5'd5, 16'hBEEF);
    mem_valid = 1'b0;
    #1 chk("alu_ready_after_mem", alu_ready, 1);
    step(5'd2, 16'h0222);
    alu_valid = 1'b0;

    // Fill the queue, ignored fifth issue, push+pop when full
    for (int i = 1; i <= 4; i++) begin
      ld_issue = 1'b1; ld_reg = 5'(i);
      #1 chk("ld_ready_fill", ld_ready, 1);
      step(5'd31, 16'h0000);
    end
    ld_reg = 5'd9;
    #1 chk("ld_ready_full", ld_ready, 0);
    step(5'd31, 16'h0000);
    ld_reg = 5'd6; mem_valid = 1'b1; mem_data = 16'hA001;
    #1 chk("ld_ready_full_popping", ld_ready, 1);
    step(5'd1, 16'hA001);
    ld_issue = 1'b0; mem_valid = 1'b0;
    #1 chk("ld_ready_still_full", ld_ready, 0);
    mem_valid = 1'b1;
    mem_data = 16'hA002; step(5'd2, 16'hA002);
    mem_data = 16'hA003; step(5'd3, 16'hA003);
    mem_data = 16'hA004; step(5'd4, 16'hA004);
    mem_data = 16'hA006; step(5'd6, 16'hA006);
    mem_valid = 1'b0;
    #1 chk("ld_ready_drained", ld_ready, 1);
    chk("mem_err_after_drain", mem_err, 0);

    // Hazard and WAW against pending R7
    ld_issue = 1'b1; ld_reg = 5'd7;
    step(5'd31, 16'h0000);
    ld_issue = 1'b0;
    hazA_reg = 5'd7; hazB_reg = 5'd0;
    alu_valid = 1'b1; alu_reg = 5'd7; alu_data = 16'h0777;
    #1 chk("haz_stall_pending_a", haz_stall, 32'(SB));
    chk("alu_ready_waw", alu_ready, 32'(!SB));
    step(SB ? 5'd31 : 5'd7, SB ? 16'h0000 : 16'h0777);
    alu_valid = 1'b0;
    hazA_reg = 5'd0; hazB_reg = 5'd7;
    mem_valid = 1'b1; mem_data = 16'h7777;
    #1 chk("haz_stall_popping_b", haz_stall, 32'(SB));
    step(5'd7, 16'h7777);
    mem_valid = 1'b0;
    #1 chk("haz_stall_after_pop", haz_stall, 0);
    hazB_reg = 5'd0;

    // Response with empty queue: dropped, ALU takes the slot, sticky error
    mem_valid = 1'b1; mem_data = 16'hDEAD;
    alu_valid = 1'b1; alu_reg = 5'd4; alu_data = 16'h0444;
    #1 chk("alu_ready_spurious_mem", alu_ready, 1);
    step(5'd4, 16'h0444);
    mem_valid = 1'b0; alu_valid = 1'b0;
    chk("mem_err_set", mem_err, 1);
    step(5'd31, 16'h0000);
    chk("mem_err_sticky", mem_err, 1);

    // Reset with two loads pending
    ld_issue = 1'b1; ld_reg = 5'd8;  step(5'd31, 16'h0000);
    ld_reg = 5'd10;                  step(5'd31, 16'h0000);
    ld_issue = 1'b0;
    RSTb = 1'b0;
    step(5'd31, 16'h0000);
    RSTb = 1'b1;
    hazA_reg = 5'd8;
    #1 chk("rst_mem_err_clear", mem_err, 0);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_haz_stall_flushed", haz_stall, 0);
    mem_valid = 1'b1; mem_data = 16'h1111;
    step(5'd31, 16'h0000);
    mem_valid = 1'b0;
    chk("rst_queue_empty_err", mem_err, 1);

    @(negedge CLK);
    #1;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
